// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared state encoding, header indices and checksum fold for the UDP deframer
package udp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_t;

  localparam int UDP_HDR_BYTES = 8;

  localparam logic [1:0] HDR_SRC  = 2'd0;
  localparam logic [1:0] HDR_DST  = 2'd1;
  localparam logic [1:0] HDR_LEN  = 2'd2;
  localparam logic [1:0] HDR_CSUM = 2'd3;

  // End-around carry; a 17-bit sum of two 16-bit words never carries twice.
  function automatic logic [15:0] csum_fold(input logic [16:0] sum);
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// rtl/udp_csum_acc.sv - ones'-complement word accumulator; o_sum already includes i_word when i_add is high
module udp_csum_acc
  import udp_rx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [15:0] i_word,
  output logic [15:0] o_sum
);

  logic [15:0] acc;

  assign o_sum = i_add ? csum_fold({1'b0, acc} + {1'b0, i_word}) : acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
    end else if (i_clear) begin
      acc <= '0;
    end else if (i_add) begin
      acc <= o_sum;
    end
  end

endmodule

// File: rtl/udp_rx_deframer.sv
// rtl/udp_rx_deframer.sv - serial UDP receiver: word assembly, header parse, framing errors
// Checksum verification is built only when UDP_RX_CSUM_EN is defined.
module udp_rx_deframer
  import udp_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 1472
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_udp_data,
  input  logic                  i_udp_valid,
  input  logic                  i_udp_sof,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [15:0]           o_src_port,
  output logic [15:0]           o_dst_port,
  output logic [15:0]           o_length,
  output logic                  o_hdr_valid,
  output logic                  o_pkt_done,
  output logic                  o_pkt_ok,
  output logic                  o_err_len,
  output logic                  o_err_ovf,
  output logic                  o_err_csum
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] MIN_LEN_W = 16'(UDP_HDR_BYTES);

  rx_state_t   state;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] word_cnt;
  logic [15:0] word_in;
  logic        sof_take;
  logic        bit_take;
  logic        word_done;
  logic        ovf;
  logic        len_bad;
  logic        is_last;
  logic        pkt_end;
  logic        csum_bad;

  assign sof_take  = i_udp_valid && i_udp_sof;
  assign bit_take  = i_udp_valid && !i_udp_sof && (state == ST_HDR || state == ST_PAYLOAD);
  assign word_in   = shreg | ({15'd0, i_udp_data} << bit_cnt);
  assign word_done = bit_take && (bit_cnt == 4'd15);
  assign ovf       = o_word_valid && !i_word_ready;
  assign len_bad   = (word_in < MIN_LEN_W) || word_in[0] || (word_in > MAX_LEN_W);
  assign is_last   = (word_cnt + 16'd1) == {1'b0, o_length[15:1]};
  // o_length can be stale during words 0-2, so only trust it from the checksum word on.
  assign pkt_end   = is_last && (state == ST_PAYLOAD || word_cnt[1:0] == HDR_CSUM);

`ifdef UDP_RX_CSUM_EN
  logic [15:0] csum_field;
  logic [15:0] csum_field_eff;
  logic [15:0] csum_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csum_field <= '0;
    end else if (word_done && !ovf && state == ST_HDR && word_cnt[1:0] == HDR_CSUM) begin
      csum_field <= word_in;
    end
  end

  udp_csum_acc u_csum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (sof_take),
    .i_add   (word_done && !ovf),
    .i_word  (word_in),
    .o_sum   (csum_sum)
  );

  // A zero checksum field means the sender did not compute one.
  assign csum_field_eff = (state == ST_HDR) ? word_in : csum_field;
  assign csum_bad       = (csum_sum != 16'hFFFF) && (csum_field_eff != 16'h0000);
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      word_cnt     <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_src_port   <= '0;
      o_dst_port   <= '0;
      o_length     <= '0;
      o_hdr_valid  <= 1'b0;
      o_pkt_done   <= 1'b0;
      o_pkt_ok     <= 1'b0;
      o_err_len    <= 1'b0;
      o_err_ovf    <= 1'b0;
      o_err_csum   <= 1'b0;
    end else begin
      o_hdr_valid <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_pkt_ok    <= 1'b0;
      if (o_word_valid && i_word_ready) begin
        o_word_valid <= 1'b0;
      end
      if (sof_take) begin
        if (state == ST_HDR || state == ST_PAYLOAD) begin
          o_pkt_done   <= 1'b1;
          o_word_valid <= 1'b0;
        end
        state      <= ST_HDR;
        bit_cnt    <= 4'd1;
        shreg      <= {15'd0, i_udp_data};
        word_cnt   <= '0;
        o_err_len  <= 1'b0;
        o_err_ovf  <= 1'b0;
        o_err_csum <= 1'b0;
      end else if (bit_take) begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= word_done ? '0 : word_in;
        if (word_done) begin
          word_cnt <= word_cnt + 16'd1;
          if (ovf) begin
            o_err_ovf  <= 1'b1;
            o_pkt_done <= 1'b1;
            state      <= ST_DROP;
          end else begin
            o_word       <= word_in;
            o_word_valid <= 1'b1;
            o_sop        <= (word_cnt == 16'd0);
            o_eop        <= 1'b0;
            if (state == ST_HDR) begin
              case (word_cnt[1:0])
                HDR_SRC: o_src_port <= word_in;
                HDR_DST: o_dst_port <= word_in;
                HDR_LEN: begin
                  o_length <= word_in;
                  if (len_bad) begin
                    o_err_len  <= 1'b1;
                    o_pkt_done <= 1'b1;
                    state      <= ST_DROP;
                  end
                end
                HDR_CSUM: begin
                  o_hdr_valid <= 1'b1;
                  state       <= ST_PAYLOAD;
                end
              endcase
            end
            if (pkt_end) begin
              o_eop      <= 1'b1;
              o_pkt_done <= 1'b1;
              o_pkt_ok   <= !csum_bad;
              o_err_csum <= csum_bad;
              state      <= ST_IDLE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_deframer.sv
// tb/tb_udp_rx_deframer.sv - directed bench for udp_rx_deframer
module tb_udp_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        data;
  logic        valid;
  logic        sof;
  logic        ready;
  logic [15:0] o_word;
  logic        o_word_valid;
  logic        o_sop;
  logic        o_eop;
  logic [15:0] o_src_port;
  logic [15:0] o_dst_port;
  logic [15:0] o_length;
  logic        o_hdr_valid;
  logic        o_pkt_done;
  logic        o_pkt_ok;
  logic        o_err_len;
  logic        o_err_ovf;
  logic        o_err_csum;

  always #5 clk = ~clk;

  udp_rx_deframer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_udp_data   (data),
    .i_udp_valid  (valid),
    .i_udp_sof    (sof),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (ready),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_src_port   (o_src_port),
    .o_dst_port   (o_dst_port),
    .o_length     (o_length),
    .o_hdr_valid  (o_hdr_valid),
    .o_pkt_done   (o_pkt_done),
    .o_pkt_ok     (o_pkt_ok),
    .o_err_len    (o_err_len),
    .o_err_ovf    (o_err_ovf),
    .o_err_csum   (o_err_csum)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hdr_cnt = 0;
  logic [15:0] q_word[$];
  logic        q_sop[$];
  logic        q_eop[$];
  logic        q_ok[$];
  logic [15:0] pkt[8];

`ifdef UDP_RX_CSUM_EN
  localparam logic BAD_CSUM_OK  = 1'b0;
  localparam logic BAD_CSUM_ERR = 1'b1;
`else
  localparam logic BAD_CSUM_OK  = 1'b1;
  localparam logic BAD_CSUM_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_word_valid && ready) begin
        q_word.push_back(o_word);
        q_sop.push_back(o_sop);
        q_eop.push_back(o_eop);
      end
      if (o_pkt_done) q_ok.push_back(o_pkt_ok);
      if (o_hdr_valid) hdr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_obs();
    q_word.delete();
    q_sop.delete();
    q_eop.delete();
    q_ok.delete();
    hdr_cnt = 0;
  endtask

  task automatic set_pkt(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    pkt[0] = w0; pkt[1] = w1; pkt[2] = w2; pkt[3] = w3; pkt[4] = w4; pkt[5] = w5;
    pkt[6] = 16'h0; pkt[7] = 16'h0;
  endtask

  // Sends the first nbits of pkt[] LSB-first, optionally idling valid between bits.
  task automatic send_pkt(input int nbits, input bit gap);
    logic [15:0] w;
    for (int i = 0; i < nbits; i++) begin
      w     = pkt[3'(i >> 4)];
      data  = w[i[3:0]];
      valid = 1'b1;
      sof   = (i == 0);
      tick(1);
      if (gap) begin
        valid = 1'b0;
        sof   = 1'b0;
        data  = 1'b0;
        tick(1);
      end
    end
    valid = 1'b0;
    sof   = 1'b0;
    data  = 1'b0;
  endtask

  task automatic check_good(input string t, input logic [15:0] csum, input logic exp_ok);
    logic [15:0] ew;
    check({t, ".nwords"}, q_word.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ew = (i == 0) ? 16'h0007 : (i == 1) ? 16'h0002 : (i == 2) ? 16'h0008 : csum;
      check($sformatf("%s.word%0d", t, i), q_word[i], ew);
      check($sformatf("%s.sop%0d", t, i), q_sop[i], (i == 0));
      check($sformatf("%s.eop%0d", t, i), q_eop[i], (i == 3));
    end
    check({t, ".ndone"}, q_ok.size(), 1);
    check({t, ".ok"}, q_ok[0], exp_ok);
  endtask

  initial begin
    rst   = 1'b1;
    data  = 1'b0;
    valid = 1'b0;
    sof   = 1'b0;
    ready = 1'b1;
    tick(2);
    check("rst.word_valid", o_word_valid, 0);
    check("rst.word", o_word, 0);
    check("rst.length", o_length, 0);
    check("rst.errs", {o_err_len, o_err_ovf, o_err_csum}, 0);
    rst = 1'b0;
    tick(2);

    // good packet, continuous bits
    set_pkt(16'h0007, 16'h0002, 16'h0008, 16'hFFEE, 16'h0, 16'h0);
    clear_obs();
    send_pkt(64, 1'b0);
    tick(4);
    check_good("t1", 16'hFFEE, 1'b1);
    check("t1.hdr_valid", hdr_cnt, 1);
    check("t1.src", o_src_port, 16'h0007);
    check("t1.dst", o_dst_port, 16'h0002);
    check("t1.len", o_length, 16'h0008);
    check("t1.err_csum", o_err_csum, 0);

    // wrong checksum
    set_pkt(16'h0007, 16'h0002, 16'h0008, 16'h724D, 16'h0, 16'h0);
    clear_obs();
    send_pkt(64, 1'b0);
    tick(4);
    check_good("t2", 16'h724D, BAD_CSUM_OK);
    check("t2.err_csum", o_err_csum, BAD_CSUM_ERR);

    // length below header size
    set_pkt(16'h0007, 16'h0002, 16'h0004, 16'h0000, 16'h1234, 16'h0);
    clear_obs();
    send_pkt(80, 1'b0);
    tick(4);
    check("t3.err_len", o_err_len, 1);
    check("t3.nwords", q_word.size(), 3);
    check("t3.word2", q_word[2], 16'h0004);
    check("t3.eop2", q_eop[2], 0);
    check("t3.ndone", q_ok.size(), 1);
    check("t3.ok", q_ok[0], 0);
    check("t3.hdr_valid", hdr_cnt, 0);

    // overflow with downstream stalled
    ready = 1'b0;
    set_pkt(16'h0007, 16'h0002, 16'h000C, 16'h0000, 16'hAAAA, 16'h5555);
    clear_obs();
    send_pkt(96, 1'b0);
    tick(4);
    check("t4.err_ovf", o_err_ovf, 1);
    check("t4.err_len", o_err_len, 0);
    check("t4.ndone", q_ok.size(), 1);
    check("t4.ok", q_ok[0], 0);
    check("t4.pending_valid", o_word_valid, 1);
    check("t4.pending_word", o_word, 16'h0007);
    ready = 1'b1;
    tick(2);
    check("t4.flushed", q_word.size(), 1);

    // SOF at bit 40 abandons the first packet
    set_pkt(16'h0007, 16'h0002, 16'h0014, 16'h0000, 16'h0, 16'h0);
    clear_obs();
    send_pkt(40, 1'b0);
    set_pkt(16'h0007, 16'h0002, 16'h0008, 16'hFFEE, 16'h0, 16'h0);
    send_pkt(64, 1'b0);
    tick(4);
    check("t5.ndone", q_ok.size(), 2);
    check("t5.ok_abandon", q_ok[0], 0);
    check("t5.ok_new", q_ok[1], 1);
    check("t5.nwords", q_word.size(), 6);
    check("t5.sop_new", q_sop[2], 1);
    check("t5.word_new3", q_word[5], 16'hFFEE);
    check("t5.eop_new", q_eop[5], 1);

    // valid every other cycle
    clear_obs();
    send_pkt(64, 1'b1);
    tick(4);
    check_good("t6", 16'hFFEE, 1'b1);

    // reset at bit 20
    clear_obs();
    send_pkt(20, 1'b0);
    rst = 1'b1;
    #1;
    check("t7.src_async", o_src_port, 0);
    check("t7.word_valid", o_word_valid, 0);
    check("t7.word", o_word, 0);
    tick(2);
    rst = 1'b0;
    tick(40);
    check("t7.no_done", q_ok.size(), 0);
    clear_obs();
    send_pkt(64, 1'b0);
    tick(4);
    check_good("t7b", 16'hFFEE, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_deframer.md
UDP_RX_DEFRAMER -- requirements
Module: udp_rx_deframer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width; only 16 supported.
REQ-002 SHALL have parameter MAX_LEN, default 1472, largest accepted UDP length field in bytes.
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port i_udp_data, input, 1, serial UDP bit, LSB of each 16-bit word first.
REQ-006 SHALL have port i_udp_valid, input, 1, i_udp_data is sampled this cycle.
REQ-007 SHALL have port i_udp_sof, input, 1, qualifies the first bit of a packet; valid only with i_udp_valid.
REQ-008 SHALL have port o_word, output, 16, assembled word (src, dst, length, checksum, payload...).
REQ-009 SHALL have port o_word_valid, output, 1, o_word holds a word.
REQ-010 SHALL have port i_word_ready, input, 1, downstream accepts the word.
REQ-011 SHALL have ports o_sop and o_eop, output, 1 each, first/last word markers qualified by o_word_valid.
REQ-012 SHALL have ports o_src_port, o_dst_port and o_length, output, 16 each, held header fields.
REQ-013 SHALL have port o_hdr_valid, output, 1, 1-cycle pulse when header words 0-3 are all captured.
REQ-014 SHALL have ports o_pkt_done and o_pkt_ok, output, 1 each, end-of-packet pulse and status.
REQ-015 SHALL have ports o_err_len, o_err_ovf and o_err_csum, output, 1 each, sticky until next SOF.

Function
REQ-016 SHALL implement states IDLE, HDR, PAYLOAD, DROP; SOF in any state loads bit 0 and enters HDR.
REQ-017 SHALL shift a sampled bit into position k of the word on the k-th valid bit; i_udp_valid low stalls the count.
REQ-018 SHALL assert o_word_valid on the cycle after the 16th bit is sampled (1-cycle latency) and hold it until i_word_ready.
REQ-019 SHALL detect overflow when a word completes while o_word_valid=1 and i_word_ready=0; it then sets o_err_ovf and enters DROP.
REQ-020 SHALL validate length at word 2: less than 8, odd, or greater than MAX_LEN sets o_err_len and enters DROP.
REQ-021 SHALL pulse o_hdr_valid with word 3 and move HDR to PAYLOAD, or to IDLE if length=8.
REQ-022 SHALL emit length/2 words in total and assert o_eop on the last; o_sop on word 0 only.
REQ-023 SHALL compute the checksum as a 16-bit ones'-complement sum, with end-around carry, over all words including the checksum field.
REQ-024 SHALL consider the checksum OK if the final sum is 16'hFFFF or the checksum field is 16'h0000; otherwise it sets o_err_csum.
REQ-025 SHALL pulse o_pkt_done on the cycle after the last word completes; o_pkt_ok = no error flags set.
REQ-026 SHALL ignore bits in DROP until SOF; on entry to DROP it pulses o_pkt_done with o_pkt_ok=0 and suppresses o_eop.
REQ-027 SHALL abandon a packet still in progress when SOF arrives: o_pkt_done=1 and o_pkt_ok=0 next cycle, the pending output word is discarded, and a new packet starts.
REQ-028 SHALL ignore valid bits in IDLE without SOF.

Reset
REQ-029 SHALL, with i_rst=1, immediately put state IDLE, bit/word counters 0, checksum 0, and all outputs 0 (including header fields and error flags).
REQ-030 SHALL, on reset mid-packet, discard the packet with no o_pkt_done pulse.

Configuration
REQ-031 SHALL, with UDP_RX_CSUM_EN defined, implement REQ-023/024.
REQ-032 SHALL, without UDP_RX_CSUM_EN, omit the checksum adder and tie o_err_csum to 0.

Structure
REQ-033 SHALL place state encoding, header word indices (0-3), UDP_HDR_BYTES=8 and the checksum fold function in shared package udp_rx_pkg.
REQ-034 SHALL implement the checksum in sub-module udp_csum_acc (clear, add word, sum out).

Verification
REQ-035 SHALL verify: src 7, dst 2, length 8, csum 0xFFEE sent LSB-first with ready=1 -> 4 words 0x0007,0x0002,0x0008,0xFFEE; sop on word 0, eop on word 3; o_pkt_ok=1.
REQ-036 SHALL verify: same packet with csum 0x724D -> o_err_csum=1, o_pkt_ok=0 (macro on); o_pkt_ok=1 (macro off).
REQ-037 SHALL verify: length 0x0004 -> o_err_len=1 after word 2; no word 3; DROP until next SOF.
REQ-038 SHALL verify: length 12, ready held 0 -> o_err_ovf at word 1 completion, o_pkt_done with o_pkt_ok=0.
REQ-039 SHALL verify: SOF at bit 40 of a packet -> abandoned packet reports o_pkt_ok=0; the new packet parses correctly.
REQ-040 SHALL verify: i_udp_valid toggled every other cycle -> same words as REQ-035; i_rst at bit 20 -> outputs 0, no o_pkt_done.
